// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencing for the 5-stage core: reset-vector start-up, loader freeze,
// load-use stall and jump squash, with saturating stall/flush event counters.
module pipeline_hazard_controller #(
    parameter int REG_ADDR_W = 3,
    parameter int RESET_HOLD = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_uses_src1,
    input  logic                  id_uses_src2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  jump_occured,
    input  logic                  loader_active,
    output logic                  pc_write_en,
    output logic                  pc_load_reset_vec,
    output logic                  ifid_write_en,
    output logic                  ifid_flush,
    output logic                  idex_bubble,
    output logic                  pipe_hold,
    output logic [1:0]            ctrl_state,
    output logic [CNT_W-1:0]      stall_count,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [1:0] {
        ST_RESET_SEQ = 2'b00,
        ST_RUN       = 2'b01,
        ST_FREEZE    = 2'b10
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              load_use;
    logic              hold_done;
    logic              run_jump;
    logic              run_stall;

    assign load_use  = ex_mem_read & ((id_uses_src1 & (id_src1 == ex_dest)) |
                                      (id_uses_src2 & (id_src2 == ex_dest)));
    assign hold_done = (hold_cnt == HOLD_LAST);
    // A jump squashes the dependent instruction, so it masks the stall.
    assign run_jump  = !loader_active && (state == ST_RUN) && jump_occured;
    assign run_stall = !loader_active && (state == ST_RUN) && !jump_occured && load_use;
    assign ctrl_state = state;

    always_comb begin
        pc_write_en       = 1'b0;
        pc_load_reset_vec = 1'b0;
        ifid_write_en     = 1'b0;
        ifid_flush        = 1'b0;
        idex_bubble       = 1'b0;
        pipe_hold         = 1'b0;
        if (loader_active) begin
            pipe_hold = 1'b1;
        end else begin
            case (state)
                ST_RUN: begin
                    if (jump_occured) begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                        ifid_flush    = 1'b1;
                        idex_bubble   = 1'b1;
                    end else if (load_use) begin
                        idex_bubble   = 1'b1;
                    end else begin
                        pc_write_en   = 1'b1;
                        ifid_write_en = 1'b1;
                    end
                end
                ST_FREEZE: pipe_hold = 1'b1;
                default: begin
                    // Illegal encodings decode like RESET_SEQ but never load the PC.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                    if (state == ST_RESET_SEQ && hold_done) begin
                        pc_write_en       = 1'b1;
                        pc_load_reset_vec = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RESET_SEQ;
            hold_cnt    <= '0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (run_stall && stall_count != '1) stall_count <= stall_count + 1'b1;
            if (run_jump && flush_count != '1)  flush_count <= flush_count + 1'b1;
            if (loader_active) begin
                state    <= ST_FREEZE;
                hold_cnt <= '0;
            end else begin
                case (state)
                    ST_RESET_SEQ: begin
                        if (hold_done) begin
                            state    <= ST_RUN;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    ST_RUN: state <= ST_RUN;
                    default: begin
                        state    <= ST_RESET_SEQ;
                        hold_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage pipeline (F D E M W) by generating the PC, IF/ID and ID/EX enable, flush and bubble controls.
- Handles four cases: the post-reset reset-vector start-up sequence, freezing the pipeline while the instruction-memory loader is writing, load-use stalls against the EX stage, and squashing of younger instructions on a taken jump resolved in EX.
- Sits between decode/ALU stage status signals and the fetch module and pipeline registers.

Parameters:
- REG_ADDR_W, 3, register-address width; matches the 8-entry register file.
- RESET_HOLD, 2, number of cycles in RESET_SEQ, minimum 1; the last cycle loads the reset vector into the PC.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- id_src1  in  REG_ADDR_W  source reg 1 of the instruction in decode (instruction[7:5]).
- id_src2  in  REG_ADDR_W  source reg 2 of the instruction in decode (instruction[10:8]).
- id_uses_src1  in  1  decode instruction reads src1.
- id_uses_src2  in  1  decode instruction reads src2.
- ex_mem_read  in  1  instruction in EX is a load (mem_read_buf).
- ex_dest  in  REG_ADDR_W  destination register of the EX instruction.
- jump_occured  in  1  taken jump resolved in EX this cycle.
- loader_active  in  1  instruction-memory loader is writing (write_enable_fm path).
- pc_write_en  out  1  PC may update this cycle.
- pc_load_reset_vec  out  1  PC takes the reset vector instead of PC+1 or the jump target.
- ifid_write_en  out  1  IF/ID register captures.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP (control bits cleared).
- pipe_hold  out  1  EX/MEM and MEM/WB hold (freeze).
- ctrl_state  out  2  00 RESET_SEQ, 01 RUN, 10 FREEZE.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  jump flushes, saturating.

Behaviour:
- Reset (async, reset=0):
  - state=RESET_SEQ, hold counter=0, both perf counters=0.
  - Outputs follow the RESET_SEQ decode: pc_write_en=0, pc_load_reset_vec=0, ifid_write_en=0, ifid_flush=1, idex_bubble=1, pipe_hold=0.
- Outputs are combinational from the registered state and the current inputs. Zero-latency response is required for stall and flush.
- Priority, highest first: loader_active > RESET_SEQ sequencing > jump_occured > load-use.
- RESET_SEQ:
  - ifid_flush=1, idex_bubble=1, ifid_write_en=0, pc_write_en=0; the counter increments each cycle.
  - When counter==RESET_HOLD-1: pc_write_en=1 and pc_load_reset_vec=1; next state is RUN and the counter clears.
  - jump_occured is ignored in this state.
- RUN, no event: pc_write_en=1, ifid_write_en=1, flush=0, bubble=0, pipe_hold=0.
- RUN, jump_occured=1:
  - ifid_flush=1, idex_bubble=1, pc_write_en=1 (the PC takes the jump target), ifid_write_en=1.
  - flush_count increments. The flush lasts exactly 1 cycle.
- RUN, load-use hazard:
  - Hazard condition: ex_mem_read & ((id_uses_src1 & id_src1==ex_dest) | (id_uses_src2 & id_src2==ex_dest)).
  - Response: pc_write_en=0, ifid_write_en=0, idex_bubble=1; stall_count increments.
  - The next cycle EX holds the bubble (ex_mem_read=0), so the stall lasts 1 cycle per load.
- Jump and hazard in the same cycle: jump response only; stall_count is unchanged (the dependent instruction is squashed).
- FREEZE:
  - Entered from any state when loader_active=1; it overrides everything in the same cycle.
  - Outputs: pc_write_en=0, ifid_write_en=0, ifid_flush=0, idex_bubble=0, pipe_hold=1.
  - When loader_active falls, next state is RESET_SEQ with counter=0, so the newly loaded program restarts from the reset vector.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-operation (any state, including mid-RESET_SEQ or FREEZE): immediate return to RESET_SEQ with count 0 and counters cleared.
- ctrl_state never takes the value 11; if illegal state encoding is reached, it recovers to RESET_SEQ on the next edge.

Test Plan:
- Release reset, RESET_HOLD=2: cycle 0 outputs flush=1, bubble=1, pc_write_en=0; cycle 1 outputs pc_write_en=1, pc_load_reset_vec=1; cycle 2 ctrl_state=01 with all enables 1.
- RUN, ex_mem_read=1, ex_dest=3, id_src2=3, id_uses_src2=1 for 1 cycle -> pc_write_en=0, ifid_write_en=0, idex_bubble=1 that cycle only; stall_count=1. Repeat with id_uses_src2=0 -> no stall.
- RUN, jump_occured=1 -> ifid_flush=1, idex_bubble=1, pc_write_en=1 for 1 cycle; flush_count=1. Jump plus hazard in the same cycle -> flush only, stall_count unchanged.
- loader_active=1 for 5 cycles during RUN -> pipe_hold=1, all enables 0, ctrl_state=10. On release -> RESET_SEQ for 2 cycles, then RUN.
- Force 65536 load-use stalls -> stall_count stays at 0xFFFF. Pulse reset=0 mid-RESET_SEQ -> counters 0, ctrl_state=00, sequence restarts from count 0.
